traffic_ctrl_param: RTL and testbench
=====================================

# traffic_ctrl_param

Parametrised highway/country-road intersection controller: the successor to the fixed-delay two-road controller. Cycle counts for yellow, all-red, minimum highway green and maximum country green are all parameters. A compile-time pedestrian walk phase can be built in. The block sits between the road car sensor and the lamp drivers. It is a Moore machine with one clock.

## Interface
- `Y2R_CYCLES`, 3: yellow duration, in cycles, for both roads.
- `R2G_CYCLES`, 2: all-red interval before country green.
- `HWY_MIN_GREEN`, 8: minimum highway green before it can yield.
- `CNTRY_MAX_GREEN`, 10: country green timeout.
- `WALK_CYCLES`, 6: walk phase duration. Used only with `TRAFFIC_PED_EN`.
- `TIMER_W`, 8: phase timer width. Every cycle parameter must be at least 1 and at most 2^TIMER_W.
- `clk`  in  1  rising-edge clock.
- `clear_n`  in  1  reset, asynchronous, active-low.
- `x`  in  1  country-road car present (1 = car waiting).
- `ped_req`  in  1  pedestrian request, single-cycle pulse or level.
- `hwy`  out  2  highway lamp: RED=2'd0, YELLOW=2'd1, GREEN=2'd2.
- `cntry`  out  2  country lamp, same encoding as `hwy`.
- `walk`  out  1  pedestrian walk lamp.

## Operation
- State register plus a down-counting phase timer. Outputs are decoded combinationally from the state register only; there is no path from `x` to the outputs.
- On entry to any state, the timer loads (duration − 1). It decrements each cycle and saturates at 0.
- "Expired" means timer == 0 at the rising edge.
- States and lamp outputs:
  - HWY_G: hwy GREEN, cntry RED.
  - HWY_Y: hwy YELLOW, cntry RED.
  - ALL_R: hwy RED, cntry RED.
  - CNT_G: hwy RED, cntry GREEN.
  - CNT_Y: hwy RED, cntry YELLOW.
  - WALK: hwy RED, cntry RED, walk=1.
- Transitions:
  - HWY_G → HWY_Y when expired (HWY_MIN_GREEN) and (`x` or ped_pending). Otherwise stay; the timer holds at 0.
  - HWY_Y → ALL_R when expired (Y2R_CYCLES).
  - ALL_R → WALK when expired (R2G_CYCLES) and ped_pending.
  - ALL_R → CNT_G when expired (R2G_CYCLES) and no ped_pending.
  - CNT_G → CNT_Y when `x`==0 or expired (CNTRY_MAX_GREEN), whichever comes first. CNT_G therefore lasts at least 1 cycle.
  - CNT_Y → HWY_G when expired (Y2R_CYCLES).
  - WALK → CNT_G when expired (WALK_CYCLES) and `x`. WALK → HWY_G when expired (WALK_CYCLES) and no `x`.
- ped_pending: sticky flag.
  - Set on any edge where `ped_req`=1, in any state.
  - Cleared on entry to WALK.
  - A request sampled on the same edge as WALK entry stays pending.
- `x` is sampled only at clock edges. `x` changes that fall inside a timed state have no effect until the state's exit condition is evaluated.
- Illegal state encodings return to HWY_G on the next edge.

## Timing
- Reset is asserted asynchronously by `clear_n`=0. While reset is asserted:
  - state=HWY_G, timer=HWY_MIN_GREEN−1, ped_pending=0.
  - Outputs: hwy=GREEN, cntry=RED, walk=0, all immediately.
- Reset mid-phase (for example during CNT_G) aborts that phase at once. There is no yellow step.
- Each timed state lasts exactly its parameter count in cycles.
- Decision latency: a state exit condition true at edge n changes the lamps after edge n, with no extra pipeline stage.
- With `x` held at 1 throughout, the full cycle is HWY_MIN_GREEN + 2·Y2R_CYCLES + R2G_CYCLES + CNTRY_MAX_GREEN. With defaults that is 26 cycles.

## Configuration
- `TRAFFIC_PED_EN` defined:
  - ped_pending, the WALK state and WALK_CYCLES are active.
  - `walk` is driven as described above.
- `TRAFFIC_PED_EN` undefined:
  - `ped_req` is ignored and ped_pending is held at 0.
  - The WALK state is not generated and `walk` is tied to 0.
  - Behaviour is the plain five-state controller.

## Structure
- Package `traffic_pkg` holds:
  - Lamp encoding constants RED, YELLOW and GREEN.
  - The state enumeration HWY_G, HWY_Y, ALL_R, CNT_G, CNT_Y, WALK.
- Sub-module `phase_timer` provides:
  - A loadable, saturating down-counter of width TIMER_W.
  - Inputs: load, load value.
  - Output: expired.

## Test plan
- Reset: drop `clear_n` mid-clock → hwy=2'd2, cntry=2'd0, walk=0 before the next edge. Hold reset for 5 cycles, outputs stay put.
- Steady demand: release reset with `x`=1, defaults → hwy GREEN 8 cycles, YELLOW 3, all-red 2, cntry GREEN 10, cntry YELLOW 3, hwy GREEN again. Repeats every 26 cycles.
- Early car: `x`=1 from cycle 2 after reset → hwy stays GREEN until cycle 8. Raise `x` at cycle 20 instead → HWY_Y begins on the next edge.
- Car leaves: drop `x` 4 cycles into CNT_G → cntry YELLOW after the next edge, well short of the 10-cycle timeout.
- Reset during CNT_G → hwy GREEN and cntry RED immediately. After release, the minimum green of 8 cycles is counted afresh.
- `TRAFFIC_PED_EN`, `x`=0, single-cycle `ped_req` pulse → hwy yields after min green: YELLOW 3, all-red 2, walk=1 for 6 cycles, then hwy GREEN. A second pulse during WALK causes one more walk cycle after the next min green.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp encoding and controller state enumeration for traffic_ctrl_param.
package traffic_pkg;

    typedef logic [1:0] lamp_t;

    localparam lamp_t RED    = 2'd0;
    localparam lamp_t YELLOW = 2'd1;
    localparam lamp_t GREEN  = 2'd2;

    typedef enum logic [2:0] {
        HWY_G = 3'd0,
        HWY_Y = 3'd1,
        ALL_R = 3'd2,
        CNT_G = 3'd3,
        CNT_Y = 3'd4,
        WALK  = 3'd5
    } state_e;

endpackage

// File: rtl/phase_timer.sv
// Loadable, saturating down-counter; expired is high while the count sits at zero.
module phase_timer #(
    parameter int unsigned         TIMER_W = 8,
    parameter logic [TIMER_W-1:0]  RST_VAL = '0
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               expired
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/traffic_ctrl_param.sv
// Highway/country intersection controller, Moore outputs from the state register.
// Define TRAFFIC_PED_EN to build in the pedestrian walk phase.
module traffic_ctrl_param
    import traffic_pkg::*;
#(
    parameter int unsigned Y2R_CYCLES      = 3,
    parameter int unsigned R2G_CYCLES      = 2,
    parameter int unsigned HWY_MIN_GREEN   = 8,
    parameter int unsigned CNTRY_MAX_GREEN = 10,
    parameter int unsigned WALK_CYCLES     = 6,
    parameter int unsigned TIMER_W         = 8
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       x,
    input  logic       ped_req,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       walk
);

    state_e             state_q, state_d;
    logic               ped_q;
    logic               expired;
    logic               load;
    logic [TIMER_W-1:0] load_val;

    function automatic logic [TIMER_W-1:0] dur_m1(input state_e s);
        case (s)
            HWY_Y, CNT_Y: dur_m1 = TIMER_W'(Y2R_CYCLES - 1);
            ALL_R:        dur_m1 = TIMER_W'(R2G_CYCLES - 1);
            CNT_G:        dur_m1 = TIMER_W'(CNTRY_MAX_GREEN - 1);
            WALK:         dur_m1 = TIMER_W'(WALK_CYCLES - 1);
            default:      dur_m1 = TIMER_W'(HWY_MIN_GREEN - 1);
        endcase
    endfunction

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= HWY_G;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HWY_G: if (expired && (x || ped_q)) state_d = HWY_Y;
            HWY_Y: if (expired) state_d = ALL_R;
            ALL_R: if (expired) state_d = ped_q ? WALK : CNT_G;
            CNT_G: if (!x || expired) state_d = CNT_Y;
            CNT_Y: if (expired) state_d = HWY_G;
`ifdef TRAFFIC_PED_EN
            WALK:  if (expired) state_d = x ? CNT_G : HWY_G;
`endif
            default: state_d = HWY_G;
        endcase
    end

    // Reload only on a real state change so HWY_G can idle with the timer parked at 0.
    assign load     = (state_d != state_q);
    assign load_val = dur_m1(state_d);

    phase_timer #(
        .TIMER_W (TIMER_W),
        .RST_VAL (TIMER_W'(HWY_MIN_GREEN - 1))
    ) u_timer (
        .clk      (clk),
        .clear_n  (clear_n),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

`ifdef TRAFFIC_PED_EN
    logic ped_d;

    // A request on the WALK-entry edge survives the clear.
    assign ped_d = ped_req | (ped_q & ~((state_d == WALK) & (state_q != WALK)));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            ped_q <= 1'b0;
        end else begin
            ped_q <= ped_d;
        end
    end
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_q          = 1'b0;
`endif

    always_comb begin
        hwy   = RED;
        cntry = RED;
        walk  = 1'b0;
        case (state_q)
            HWY_G: hwy   = GREEN;
            HWY_Y: hwy   = YELLOW;
            CNT_G: cntry = GREEN;
            CNT_Y: cntry = YELLOW;
`ifdef TRAFFIC_PED_EN
            WALK:  walk  = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Self-checking bench for traffic_ctrl_param: phase/elapsed-time reference model plus literal pins.
`timescale 1ns/1ps
module tb_traffic_ctrl_param;

    localparam int Y2R = 3;
    localparam int R2G = 2;
    localparam int HMG = 8;
    localparam int CMG = 10;
    localparam int WLK = 6;

    localparam int PH_HG = 0, PH_HY = 1, PH_AR = 2, PH_CG = 3, PH_CY = 4, PH_WK = 5;

    logic       clk = 1'b0;
    logic       clear_n = 1'b1;
    logic       x = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] hwy, cntry;
    logic       walk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    int m_ph = PH_HG;
    int m_el = 0;
    bit m_pend = 1'b0;

    traffic_ctrl_param #(
        .Y2R_CYCLES      (Y2R),
        .R2G_CYCLES      (R2G),
        .HWY_MIN_GREEN   (HMG),
        .CNTRY_MAX_GREEN (CMG),
        .WALK_CYCLES     (WLK),
        .TIMER_W         (8)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .x       (x),
        .ped_req (ped_req),
        .hwy     (hwy),
        .cntry   (cntry),
        .walk    (walk)
    );

    always #5 clk = ~clk;

    function automatic int dur(input int p);
        case (p)
            PH_HY, PH_CY: return Y2R;
            PH_AR:        return R2G;
            PH_CG:        return CMG;
            PH_WK:        return WLK;
            default:      return HMG;
        endcase
    endfunction

    // {hwy, cntry, walk} for each phase
    function automatic logic [4:0] lamps(input int p);
        case (p)
            PH_HG:   return {2'd2, 2'd0, 1'b0};
            PH_HY:   return {2'd1, 2'd0, 1'b0};
            PH_CG:   return {2'd0, 2'd2, 1'b0};
            PH_CY:   return {2'd0, 2'd1, 1'b0};
            PH_WK:   return {2'd0, 2'd0, 1'b1};
            default: return {2'd0, 2'd0, 1'b0};
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: phase plus cycles already spent in it; a phase of length D is done
    // once D cycles have elapsed.
    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            m_ph   <= PH_HG;
            m_el   <= 0;
            m_pend <= 1'b0;
        end else begin
            int e;
            int nx;
            bit ex;
            bit np;
            e  = m_el + 1;
            ex = (e >= dur(m_ph));
            nx = m_ph;
            case (m_ph)
                PH_HG:   if (ex && (x || m_pend)) nx = PH_HY;
                PH_HY:   if (ex) nx = PH_AR;
                PH_AR:   if (ex) nx = m_pend ? PH_WK : PH_CG;
                PH_CG:   if (!x || ex) nx = PH_CY;
                PH_CY:   if (ex) nx = PH_HG;
                PH_WK:   if (ex) nx = x ? PH_CG : PH_HG;
                default: nx = PH_HG;
            endcase
`ifdef TRAFFIC_PED_EN
            np = ped_req || (m_pend && !(nx == PH_WK && m_ph != PH_WK));
`else
            np = 1'b0;
`endif
            m_ph   <= nx;
            m_el   <= (nx != m_ph) ? 0 : e;
            m_pend <= np;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [4:0] e;
            e = lamps(m_ph);
            check("hwy_vs_model", int'(hwy), int'(e[4:3]));
            check("cntry_vs_model", int'(cntry), int'(e[2:1]));
            check("walk_vs_model", int'(walk), int'(e[0]));
        end
    end

    // Mid-clock async reset held 5 cycles; returns on the negedge where reset is released.
    task automatic do_reset(input logic xv, input logic pv);
        @(posedge clk);
        #2 clear_n = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_hwy_now", int'(hwy), 2);
        check("rst_cntry_now", int'(cntry), 0);
        check("rst_walk_now", int'(walk), 0);
        repeat (5) @(negedge clk);
        check("rst_hold_hwy", int'(hwy), 2);
        check("rst_hold_cntry", int'(cntry), 0);
        x       = xv;
        ped_req = pv;
        clear_n = 1'b1;
    endtask

    // Advance from cycle 'cur' to cycle 't' (cycle 0 = after reset release).
    task automatic goto(inout int cur, input int t);
        repeat (t - cur) @(negedge clk);
        cur = t;
    endtask

    task automatic pin(input string nm, input int ph, input int h, input int c);
        logic [4:0] e;
        e = lamps(ph);
        check({nm, "_model_hwy"}, int'(e[4:3]), h);
        check({nm, "_model_cntry"}, int'(e[2:1]), c);
        check({nm, "_hwy"}, int'(hwy), h);
        check({nm, "_cntry"}, int'(cntry), c);
    endtask

    int cyc_t[10] = '{7, 8, 10, 11, 12, 13, 22, 23, 25, 26};
    int hwy_t[10] = '{2, 1, 1, 0, 0, 0, 0, 0, 0, 2};
    int cnt_t[10] = '{0, 0, 0, 0, 0, 2, 2, 1, 1, 0};

    initial begin
        int cur;

        // Steady demand: 8/3/2/10/3 then highway green again.
        do_reset(1'b1, 1'b0);
        cur = 0;
        for (int i = 0; i < 10; i++) begin
            goto(cur, cyc_t[i]);
            pin($sformatf("steady_c%0d", cyc_t[i]), m_ph, hwy_t[i], cnt_t[i]);
        end

        // Early car at cycle 2: still yields only at cycle 8.
        do_reset(1'b0, 1'b0);
        cur = 0;
        goto(cur, 2);
        x = 1'b1;
        goto(cur, 7);
        pin("early_c7", m_ph, 2, 0);
        goto(cur, 8);
        pin("early_c8", m_ph, 1, 0);

        // Late car at cycle 20: yellow from the next edge.
        do_reset(1'b0, 1'b0);
        cur = 0;
        goto(cur, 20);
        pin("late_c20", m_ph, 2, 0);
        x = 1'b1;
        goto(cur, 21);
        pin("late_c21", m_ph, 1, 0);

        // Car leaves 4 cycles into country green.
        do_reset(1'b1, 1'b0);
        cur = 0;
        goto(cur, 17);
        x = 1'b0;
        pin("leave_c17", m_ph, 0, 2);
        goto(cur, 18);
        pin("leave_c18", m_ph, 0, 1);

        // Reset during country green, then a fresh minimum green.
        do_reset(1'b1, 1'b0);
        cur = 0;
        goto(cur, 15);
        check("cntg_before_rst", int'(cntry), 2);
        do_reset(1'b1, 1'b0);
        cur = 0;
        goto(cur, 7);
        pin("afresh_c7", m_ph, 2, 0);
        goto(cur, 8);
        pin("afresh_c8", m_ph, 1, 0);

`ifdef TRAFFIC_PED_EN
        // Pedestrian pulse with no cars, then a second pulse during walk.
        do_reset(1'b0, 1'b1);
        cur = 0;
        goto(cur, 1);
        ped_req = 1'b0;
        goto(cur, 8);
        pin("ped_c8", m_ph, 1, 0);
        goto(cur, 13);
        check("ped_walk_c13", int'(walk), 1);
        goto(cur, 14);
        ped_req = 1'b1;
        goto(cur, 15);
        ped_req = 1'b0;
        goto(cur, 18);
        check("ped_walk_c18", int'(walk), 1);
        goto(cur, 19);
        check("ped_walk_c19", int'(walk), 0);
        pin("ped_c19", m_ph, 2, 0);
        goto(cur, 26);
        pin("ped_c26", m_ph, 2, 0);
        goto(cur, 27);
        pin("ped_c27", m_ph, 1, 0);
        goto(cur, 32);
        check("ped2_walk_c32", int'(walk), 1);
        goto(cur, 37);
        check("ped2_walk_c37", int'(walk), 1);
        goto(cur, 38);
        check("ped2_walk_c38", int'(walk), 0);
        pin("ped2_c38", m_ph, 2, 0);
`else
        // Without the walk phase, a request alone never takes green from the highway.
        do_reset(1'b0, 1'b1);
        cur = 0;
        goto(cur, 1);
        ped_req = 1'b0;
        goto(cur, 30);
        pin("noped_c30", m_ph, 2, 0);
        check("noped_walk", int'(walk), 0);
`endif

        // Randomised traffic against the model.
        repeat (1500) begin
            @(negedge clk);
            if ($urandom_range(11) == 0) x = ~x;
            ped_req = ($urandom_range(24) == 0);
            if ($urandom_range(399) == 0) do_reset(x, 1'b0);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
